sram_controller: RTL

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller_if.sv | 45 ++++
 rtl/sram_controller.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sram_controller_if.sv
// -----------------------------------------------------------------------------
// sram_controller_if
//   Bundles the MEM-stage request/response signals and the external 16-bit
//   SRAM pins seen by sram_controller.
//
//   master : the pipeline plus the SRAM device. It drives the request fields
//            and the SRAM read data.
//   slave  : the controller. It drives the load data, ready and the SRAM
//            address/data/strobe pins.
//
//   Signals
//     rdEn, wrEn   read / write request
//     address      byte address of the request
//     writeData    store data
//     readData     load data (registered in the controller)
//     ready        request complete; the pipeline freeze is ~ready
//     sramAddr     SRAM halfword address
//     sramDqOut    data driven to the SRAM
//     sramDqIn     data returned by the SRAM
//     sramDqOe     data-bus output enable
//     sramWeN      SRAM write strobe, active-low
// -----------------------------------------------------------------------------
interface sram_controller_if;
    logic        rdEn;
    logic        wrEn;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        ready;
    logic [17:0] sramAddr;
    logic [15:0] sramDqOut;
    logic [15:0] sramDqIn;
    logic        sramDqOe;
    logic        sramWeN;

    modport master (
        output rdEn, wrEn, address, writeData, sramDqIn,
        input  readData, ready, sramAddr, sramDqOut, sramDqOe, sramWeN
    );

    modport slave (
        input  rdEn, wrEn, address, writeData, sramDqIn,
        output readData, ready, sramAddr, sramDqOut, sramDqOe, sramWeN
    );
endinterface

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
//   Turns one 32-bit MEM-stage load or store into two 16-bit accesses on an
//   external SRAM: low halfword first, then high halfword. Each access is held
//   for PHASE_CYCLES clocks. ready is low while an access is in flight, so the
//   pipeline freezes for 2*PHASE_CYCLES+1 cycles per request.
//
//   Parameters
//     BASE_ADDR     byte address that maps to SRAM word 0
//     PHASE_CYCLES  clocks per halfword access, 1..15
//
//   Ports
//     clk   single clock, rising edge
//     rst   synchronous, active-high reset
//     bus   sram_controller_if.slave (request, response and SRAM pins)
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting; a request here is latched and the low access starts
//   LOW   | low halfword access (wIdx*2), cnt counts the phase down
//   HIGH  | high halfword access (wIdx*2+1), cnt counts the phase down
//   DONE  | one cycle with ready=1, then back to IDLE
// -----------------------------------------------------------------------------
module sram_controller #(
    parameter int BASE_ADDR    = 1024,
    parameter int PHASE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    sram_controller_if.slave  bus
);

    localparam logic [3:0]  CNT_LOAD = 4'(PHASE_CYCLES - 1);
    localparam logic [31:0] BASE     = 32'(BASE_ADDR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state,     state_nxt;
    logic [3:0]  cnt,       cnt_nxt;
    logic        is_write,  is_write_nxt;
    logic [15:0] wr_hi,     wr_hi_nxt;
    logic [31:0] rd_data,   rd_data_nxt;
    logic [17:0] sram_addr, sram_addr_nxt;
    logic [15:0] dq_out,    dq_out_nxt;
    logic        dq_oe,     dq_oe_nxt;
    logic        we_n,      we_n_nxt;

    logic        req;
    logic [16:0] w_idx;

    assign req = bus.rdEn | bus.wrEn;

    // Subtraction wraps modulo 2^32; everything above word-index bit 16 is
    // dropped, so out-of-range addresses alias into the SRAM silently.
    assign w_idx = 17'((bus.address - BASE) >> 2);

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        is_write_nxt  = is_write;
        wr_hi_nxt     = wr_hi;
        rd_data_nxt   = rd_data;
        sram_addr_nxt = sram_addr;
        dq_out_nxt    = dq_out;
        dq_oe_nxt     = dq_oe;
        we_n_nxt      = we_n;

        unique case (state)
            IDLE: begin
                if (req) begin
                    state_nxt     = LOW;
                    cnt_nxt       = CNT_LOAD;
                    // A simultaneous read is dropped in favour of the write.
                    is_write_nxt  = bus.wrEn;
                    wr_hi_nxt     = bus.writeData[31:16];
                    // SRAM pins are registered, so the low access is set up
                    // on the same edge that enters LOW.
                    sram_addr_nxt = {w_idx, 1'b0};
                    dq_out_nxt    = bus.writeData[15:0];
                    dq_oe_nxt     = bus.wrEn;
                    we_n_nxt      = ~bus.wrEn;
                end
            end

            LOW: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd0) begin
                    if (!is_write) begin
                        rd_data_nxt[15:0] = bus.sramDqIn;
                    end
                    state_nxt        = HIGH;
                    cnt_nxt          = CNT_LOAD;
                    sram_addr_nxt[0] = 1'b1;
                    dq_out_nxt       = wr_hi;
                end
            end

            HIGH: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd0) begin
                    if (!is_write) begin
                        rd_data_nxt[31:16] = bus.sramDqIn;
                    end
                    state_nxt = DONE;
                    cnt_nxt   = 4'd0;
                    dq_oe_nxt = 1'b0;
                    we_n_nxt  = 1'b1;
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            is_write  <= 1'b0;
            wr_hi     <= 16'd0;
            rd_data   <= 32'd0;
            sram_addr <= 18'd0;
            dq_out    <= 16'd0;
            dq_oe     <= 1'b0;
            we_n      <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            is_write  <= is_write_nxt;
            wr_hi     <= wr_hi_nxt;
            rd_data   <= rd_data_nxt;
            sram_addr <= sram_addr_nxt;
            dq_out    <= dq_out_nxt;
            dq_oe     <= dq_oe_nxt;
            we_n      <= we_n_nxt;
        end
    end

    // ready is combinational so an idle pipeline never sees a freeze bubble.
    assign bus.ready     = (state == DONE) | ((state == IDLE) & ~req);
    assign bus.readData  = rd_data;
    assign bus.sramAddr  = sram_addr;
    assign bus.sramDqOut = dq_out;
    assign bus.sramDqOe  = dq_oe;
    assign bus.sramWeN   = we_n;

endmodule
